asr_port_arbiter: RTL and testbench

Sequencer and arbiter in front of the single-ported ASR register file. It gives the integer unit (IU) RDASR/WRASR access with SPARC delayed-write semantics: WRASR commits a fixed number of cycles after issue, and a read that hits a pending write stalls. It also shares the same port with a lower-priority debug requester. It sits between the IU/debug logic and the register file's `asr_wr`/`asr_sel`/`asr_in`/`asr_out` port.

---
 rtl/asr_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_asr_port_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asr_port_arbiter.sv
// ASR register-file port sequencer: delayed IU writes, read-after-write stall, debug sharing.
// Debug port and starvation logic exist only when ASR_ARB_DEBUG_PORT_EN is defined.
module asr_port_arbiter #(
  parameter int unsigned WR_DELAY     = 3,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iu_req,
  input  logic        iu_we,
  input  logic [4:0]  iu_sel,
  input  logic [31:0] iu_wdata,
  output logic        iu_gnt,
  output logic        iu_rvalid,
  output logic [31:0] iu_rdata,
  output logic        iu_err,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [4:0]  dbg_sel,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic        dbg_err,
  output logic        asr_wr,
  output logic [4:0]  asr_sel,
  output logic [31:0] asr_in,
  input  logic [31:0] asr_out
);

  localparam bit          Delayed = (WR_DELAY > 0);
  localparam int unsigned Stages  = Delayed ? WR_DELAY : 1;

  logic [Stages-1:0] dl_valid_q, dl_valid_d;
  logic [4:0]        dl_sel_q  [Stages];
  logic [4:0]        dl_sel_d  [Stages];
  logic [31:0]       dl_data_q [Stages];
  logic [31:0]       dl_data_d [Stages];

  logic commit, hazard;
  logic iu_sel_zero, iu_port_req, iu_free_req, iu_port_gnt;
  logic dbg_starved, dbg_port_gnt;
  logic iu_rvalid_q, iu_err_q;
  logic [31:0] iu_rdata_q;

  // Pending writes are dropped during reset, including one already at the tail.
  assign commit = Delayed && dl_valid_q[Stages-1] && !rst;

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < Stages; i++) begin
      if (dl_valid_q[i] && (dl_sel_q[i] == iu_sel)) hazard = 1'b1;
    end
  end

  // Delayed IU writes and sel 0 accesses never need the port.
  assign iu_sel_zero = (iu_sel == 5'd0);
  assign iu_port_req = iu_req && !iu_sel_zero && (!iu_we || !Delayed);
  assign iu_free_req = iu_req && (iu_sel_zero || (iu_we && Delayed));
  assign iu_port_gnt = iu_port_req && !rst && !commit && !dbg_starved && !(hazard && !iu_we);
  assign iu_gnt      = (iu_free_req && !rst) || iu_port_gnt;

`ifdef ASR_ARB_DEBUG_PORT_EN
  localparam logic [7:0] StarveMax = 8'(STARVE_LIMIT);

  logic [7:0]  starve_cnt_q, starve_cnt_d;
  logic        dbg_sel_zero, dbg_port_req;
  logic        dbg_rvalid_q, dbg_err_q;
  logic [31:0] dbg_rdata_q;

  assign dbg_sel_zero = (dbg_sel == 5'd0);
  assign dbg_port_req = dbg_req && !dbg_sel_zero;
  assign dbg_starved  = dbg_port_req && (starve_cnt_q >= StarveMax);
  assign dbg_port_gnt = dbg_port_req && !rst && !commit && !iu_port_gnt;
  assign dbg_gnt      = (dbg_req && dbg_sel_zero && !rst) || dbg_port_gnt;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (dbg_gnt) begin
      starve_cnt_d = 8'd0;
    end else if (dbg_req && (starve_cnt_q < StarveMax)) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= 8'd0;
      dbg_rvalid_q <= 1'b0;
      dbg_err_q    <= 1'b0;
      dbg_rdata_q  <= 32'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      dbg_rvalid_q <= dbg_gnt && !dbg_we;
      dbg_err_q    <= dbg_gnt && dbg_sel_zero;
      dbg_rdata_q  <= (dbg_gnt && !dbg_we && !dbg_sel_zero) ? asr_out : 32'd0;
    end
  end

  assign dbg_rvalid = dbg_rvalid_q;
  assign dbg_err    = dbg_err_q;
  assign dbg_rdata  = dbg_rdata_q;
`else
  logic unused_dbg;
  assign unused_dbg   = (^{dbg_req, dbg_we, dbg_sel, dbg_wdata}) ^ (STARVE_LIMIT == 0);
  assign dbg_starved  = 1'b0;
  assign dbg_port_gnt = 1'b0;
  assign dbg_gnt      = 1'b0;
  assign dbg_rvalid   = 1'b0;
  assign dbg_err      = 1'b0;
  assign dbg_rdata    = 32'd0;
`endif

  // Single owner per cycle: commit, then IU, then debug (starvation folded into iu_port_gnt).
  always_comb begin
    asr_wr  = 1'b0;
    asr_sel = 5'd0;
    asr_in  = 32'd0;
    if (commit) begin
      asr_wr  = 1'b1;
      asr_sel = dl_sel_q[Stages-1];
      asr_in  = dl_data_q[Stages-1];
    end else if (iu_port_gnt) begin
      asr_wr  = iu_we;
      asr_sel = iu_sel;
      asr_in  = iu_we ? iu_wdata : 32'd0;
    end else if (dbg_port_gnt) begin
      asr_wr  = dbg_we;
      asr_sel = dbg_sel;
      asr_in  = dbg_we ? dbg_wdata : 32'd0;
    end
  end

  always_comb begin
    dl_valid_d    = '0;
    dl_valid_d[0] = Delayed && iu_gnt && iu_we && !iu_sel_zero;
    dl_sel_d[0]   = iu_sel;
    dl_data_d[0]  = iu_wdata;
    for (int i = 1; i < Stages; i++) begin
      dl_valid_d[i] = dl_valid_q[i-1];
      dl_sel_d[i]   = dl_sel_q[i-1];
      dl_data_d[i]  = dl_data_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dl_valid_q  <= '0;
      iu_rvalid_q <= 1'b0;
      iu_err_q    <= 1'b0;
      iu_rdata_q  <= 32'd0;
    end else begin
      dl_valid_q  <= dl_valid_d;
      iu_rvalid_q <= iu_gnt && !iu_we;
      iu_err_q    <= iu_gnt && iu_sel_zero;
      iu_rdata_q  <= (iu_gnt && !iu_we && !iu_sel_zero) ? asr_out : 32'd0;
    end
    dl_sel_q  <= dl_sel_d;
    dl_data_q <= dl_data_d;
  end

  assign iu_rvalid = iu_rvalid_q;
  assign iu_err    = iu_err_q;
  assign iu_rdata  = iu_rdata_q;

endmodule

// File: tb/tb_asr_port_arbiter.sv
// Directed bench for asr_port_arbiter (WR_DELAY=3, STARVE_LIMIT=8) with a behavioural register file.
`timescale 1ns/1ps
module tb_asr_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        iu_req, iu_we, iu_gnt, iu_rvalid, iu_err;
  logic [4:0]  iu_sel;
  logic [31:0] iu_wdata, iu_rdata;
  logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid, dbg_err;
  logic [4:0]  dbg_sel;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic        asr_wr;
  logic [4:0]  asr_sel;
  logic [31:0] asr_in, asr_out;
  logic [31:0] rf [32];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  asr_port_arbiter #(.WR_DELAY(3), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .iu_req(iu_req), .iu_we(iu_we), .iu_sel(iu_sel), .iu_wdata(iu_wdata),
    .iu_gnt(iu_gnt), .iu_rvalid(iu_rvalid), .iu_rdata(iu_rdata), .iu_err(iu_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_sel(dbg_sel), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .asr_wr(asr_wr), .asr_sel(asr_sel), .asr_in(asr_in), .asr_out(asr_out)
  );

  // Register file: asynchronous read; write applied mid-cycle, visible to the next cycle.
  assign asr_out = rf[asr_sel];
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'hA500_0000 | 32'(i);
    end else if (asr_wr) begin
      rf[asr_sel] <= asr_in;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iu_req = 1'b0; iu_we = 1'b0; iu_sel = 5'd0; iu_wdata = 32'd0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_sel = 5'd0; dbg_wdata = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    iu_req = 1'b1; iu_sel = 5'd4;
    dbg_req = 1'b1; dbg_sel = 5'd4;
    tick();
    tick();
    @(negedge clk);
    checks++; if (iu_gnt !== 1'b0) begin errors++; $display("FAIL rst_iu_gnt: got %b want 0", iu_gnt); end
    checks++; if (dbg_gnt !== 1'b0) begin errors++; $display("FAIL rst_dbg_gnt: got %b want 0", dbg_gnt); end
    checks++;
    if ({iu_rvalid, iu_err, iu_rdata} !== 34'd0) begin
      errors++; $display("FAIL rst_iu_resp: got rv=%b err=%b rdata=%h want 0", iu_rvalid, iu_err, iu_rdata);
    end
    checks++;
    if ({dbg_rvalid, dbg_err, dbg_rdata} !== 34'd0) begin
      errors++; $display("FAIL rst_dbg_resp: got rv=%b err=%b rdata=%h want 0", dbg_rvalid, dbg_err, dbg_rdata);
    end
    checks++;
    if ({asr_wr, asr_sel, asr_in} !== 38'd0) begin
      errors++; $display("FAIL rst_port_idle: got wr=%b sel=%0d in=%h want 0", asr_wr, asr_sel, asr_in);
    end
    tick();
    rst = 1'b0;
    idle();
  endtask

  task automatic test_delayed_write();
    logic exp_wr;
    tick();  // N
    iu_req = 1'b1; iu_we = 1'b1; iu_sel = 5'd17; iu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (iu_gnt !== 1'b1) begin errors++; $display("FAIL dw_grant: got %b want 1", iu_gnt); end
    checks++; if (asr_wr !== 1'b0) begin errors++; $display("FAIL dw_issue_port: got wr=%b want 0", asr_wr); end
    tick();  // N+1: dependent read
    iu_we = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) tick();
      @(negedge clk);
      exp_wr = (c == 3);
      checks++;
      if (iu_gnt !== 1'b0) begin errors++; $display("FAIL dw_stall N+%0d: got gnt=%b want 0", c, iu_gnt); end
      checks++;
      if (asr_wr !== exp_wr) begin errors++; $display("FAIL dw_commit_wr N+%0d: got %b want %b", c, asr_wr, exp_wr); end
    end
    checks++;
    if ({asr_sel, asr_in} !== {5'd17, 32'hDEADBEEF}) begin
      errors++; $display("FAIL dw_commit_data: got sel=%0d in=%h want 17 deadbeef", asr_sel, asr_in);
    end
    tick();  // N+4
    @(negedge clk);
    checks++;
    if (iu_gnt !== 1'b1 || asr_sel !== 5'd17) begin
      errors++; $display("FAIL dw_read_grant: got gnt=%b sel=%0d want 1 17", iu_gnt, asr_sel);
    end
    tick();  // N+5
    idle();
    @(negedge clk);
    checks++;
    if (iu_rvalid !== 1'b1 || iu_rdata !== 32'hDEADBEEF || iu_err !== 1'b0) begin
      errors++; $display("FAIL dw_read_data: got rv=%b rdata=%h err=%b want 1 deadbeef 0", iu_rvalid, iu_rdata, iu_err);
    end
  endtask

  task automatic test_no_hazard();
    tick();  // N
    iu_req = 1'b1; iu_we = 1'b1; iu_sel = 5'd5; iu_wdata = 32'h0000_0055;
    tick();  // N+1
    iu_we = 1'b0; iu_sel = 5'd6;
    @(negedge clk);
    checks++; if (iu_gnt !== 1'b1) begin errors++; $display("FAIL nh_grant: got %b want 1", iu_gnt); end
    tick();  // N+2
    idle();
    @(negedge clk);
    checks++;
    if (iu_rvalid !== 1'b1 || iu_rdata !== 32'hA500_0006) begin
      errors++; $display("FAIL nh_read_data: got rv=%b rdata=%h want 1 a5000006", iu_rvalid, iu_rdata);
    end
    tick();  // N+3
    @(negedge clk);
    checks++;
    if ({asr_wr, asr_sel, asr_in} !== {1'b1, 5'd5, 32'h0000_0055}) begin
      errors++; $display("FAIL nh_commit: got wr=%b sel=%0d in=%h want 1 5 55", asr_wr, asr_sel, asr_in);
    end
  endtask

  task automatic test_sel0();
    int wr_seen;
    wr_seen = 0;
    tick();
    iu_req = 1'b1; iu_we = 1'b0; iu_sel = 5'd0;
    @(negedge clk);
    checks++; if (iu_gnt !== 1'b1) begin errors++; $display("FAIL s0_read_grant: got %b want 1", iu_gnt); end
    checks++;
    if ({asr_wr, asr_sel, asr_in} !== 38'd0) begin
      errors++; $display("FAIL s0_read_port: got wr=%b sel=%0d in=%h want 0", asr_wr, asr_sel, asr_in);
    end
    tick();
    iu_we = 1'b1; iu_wdata = 32'h0000_0077;
    @(negedge clk);
    if (asr_wr !== 1'b0) wr_seen++;
    checks++;
    if (iu_rvalid !== 1'b1 || iu_err !== 1'b1 || iu_rdata !== 32'd0) begin
      errors++; $display("FAIL s0_read_resp: got rv=%b err=%b rdata=%h want 1 1 0", iu_rvalid, iu_err, iu_rdata);
    end
    checks++; if (iu_gnt !== 1'b1) begin errors++; $display("FAIL s0_write_grant: got %b want 1", iu_gnt); end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (iu_err !== 1'b1 || iu_rvalid !== 1'b0) begin
      errors++; $display("FAIL s0_write_err: got err=%b rv=%b want 1 0", iu_err, iu_rvalid);
    end
    for (int c = 0; c < 4; c++) begin
      if (asr_wr !== 1'b0) wr_seen++;
      tick();
      @(negedge clk);
    end
    checks++;
    if (wr_seen !== 0) begin errors++; $display("FAIL s0_no_write: got %0d write cycles want 0", wr_seen); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_data;
    for (int i = 0; i <= 3; i++) begin
      tick();
      if (i < 3) begin
        iu_req = 1'b1; iu_we = 1'b0; iu_sel = 5'(i + 1);
      end else begin
        idle();
      end
      @(negedge clk);
      if (i < 3) begin
        checks++;
        if (iu_gnt !== 1'b1) begin errors++; $display("FAIL b2b_grant %0d: got %b want 1", i, iu_gnt); end
      end
      if (i > 0) begin
        exp_data = 32'hA500_0000 | 32'(i);
        checks++;
        if (iu_rvalid !== 1'b1 || iu_rdata !== exp_data) begin
          errors++; $display("FAIL b2b_data %0d: got rv=%b rdata=%h want 1 %h", i, iu_rvalid, iu_rdata, exp_data);
        end
      end
    end
  endtask

`ifdef ASR_ARB_DEBUG_PORT_EN
  task automatic test_starvation();
    int bad;
    bad = 0;
    tick();  // M
    iu_req = 1'b1; iu_we = 1'b0; iu_sel = 5'd7;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_sel = 5'd9;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick();
      @(negedge clk);
      if (dbg_gnt !== 1'b0 || iu_gnt !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL sv_wait: got %0d bad cycles in M..M+7 want 0", bad); end
    tick();  // M+8
    @(negedge clk);
    checks++;
    if (dbg_gnt !== 1'b1 || iu_gnt !== 1'b0 || asr_sel !== 5'd9) begin
      errors++; $display("FAIL sv_win: got dgnt=%b igt=%b sel=%0d want 1 0 9", dbg_gnt, iu_gnt, asr_sel);
    end
    tick();  // M+9
    dbg_sel = 5'd10;
    @(negedge clk);
    checks++;
    if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'hA500_0009) begin
      errors++; $display("FAIL sv_data: got rv=%b rdata=%h want 1 a5000009", dbg_rvalid, dbg_rdata);
    end
    checks++;
    if (dbg_gnt !== 1'b0 || iu_gnt !== 1'b1) begin
      errors++; $display("FAIL sv_cleared: got dgnt=%b igt=%b want 0 1", dbg_gnt, iu_gnt);
    end
    tick();
    idle();
  endtask

  task automatic test_dbg_write();
    tick();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_sel = 5'd12; dbg_wdata = 32'hCAFE_0012;
    @(negedge clk);
    checks++;
    if (dbg_gnt !== 1'b1 || {asr_wr, asr_sel, asr_in} !== {1'b1, 5'd12, 32'hCAFE_0012}) begin
      errors++; $display("FAIL dbw_port: got gnt=%b wr=%b sel=%0d in=%h want 1 1 12 cafe0012",
                         dbg_gnt, asr_wr, asr_sel, asr_in);
    end
    tick();
    dbg_we = 1'b0; dbg_sel = 5'd0;
    @(negedge clk);
    checks++;
    if (dbg_gnt !== 1'b1 || asr_wr !== 1'b0) begin
      errors++; $display("FAIL dbs0_grant: got gnt=%b wr=%b want 1 0", dbg_gnt, asr_wr);
    end
    tick();  // N: IU write sel 13
    idle();
    iu_req = 1'b1; iu_we = 1'b1; iu_sel = 5'd13; iu_wdata = 32'h1313_1313;
    @(negedge clk);
    checks++;
    if (dbg_rvalid !== 1'b1 || dbg_err !== 1'b1 || dbg_rdata !== 32'd0) begin
      errors++; $display("FAIL dbs0_resp: got rv=%b err=%b rdata=%h want 1 1 0", dbg_rvalid, dbg_err, dbg_rdata);
    end
    tick();
    idle();
    tick();
    tick();  // N+3: commit collides with debug write
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_sel = 5'd14; dbg_wdata = 32'h0000_0014;
    @(negedge clk);
    checks++;
    if (dbg_gnt !== 1'b0 || asr_wr !== 1'b1 || asr_sel !== 5'd13) begin
      errors++; $display("FAIL dbw_vs_commit: got gnt=%b wr=%b sel=%0d want 0 1 13", dbg_gnt, asr_wr, asr_sel);
    end
    tick();  // N+4
    @(negedge clk);
    checks++;
    if (dbg_gnt !== 1'b1 || {asr_wr, asr_sel, asr_in} !== {1'b1, 5'd14, 32'h0000_0014}) begin
      errors++; $display("FAIL dbw_after_commit: got gnt=%b wr=%b sel=%0d in=%h want 1 1 14 14",
                         dbg_gnt, asr_wr, asr_sel, asr_in);
    end
    tick();
    idle();
  endtask
`else
  task automatic test_macro_off();
    int bad_dgnt, bad_wr, bad_iu, bad_dresp;
    bad_dgnt = 0; bad_wr = 0; bad_iu = 0; bad_dresp = 0;
    tick();
    iu_req = 1'b1; iu_we = 1'b0; iu_sel = 5'd2;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_sel = 5'd9; dbg_wdata = 32'h0000_0099;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      @(negedge clk);
      if (dbg_gnt !== 1'b0) bad_dgnt++;
      if (asr_wr === 1'b1 && asr_sel === 5'd9) bad_wr++;
      if (iu_gnt !== 1'b1) bad_iu++;
      if (c > 0 && (iu_rvalid !== 1'b1 || iu_rdata !== 32'hA500_0002)) bad_iu++;
      if ({dbg_rvalid, dbg_err, dbg_rdata} !== 34'd0) bad_dresp++;
    end
    checks++; if (bad_dgnt !== 0) begin errors++; $display("FAIL off_dbg_gnt: got %0d grants want 0", bad_dgnt); end
    checks++; if (bad_wr !== 0) begin errors++; $display("FAIL off_dbg_write: got %0d writes want 0", bad_wr); end
    checks++; if (bad_iu !== 0) begin errors++; $display("FAIL off_iu_traffic: got %0d bad cycles want 0", bad_iu); end
    checks++; if (bad_dresp !== 0) begin errors++; $display("FAIL off_dbg_resp: got %0d bad cycles want 0", bad_dresp); end
    tick();
    idle();
  endtask
`endif

  task automatic test_reset_mid();
    int wr_seen;
    wr_seen = 0;
    tick();  // N
    iu_req = 1'b1; iu_we = 1'b1; iu_sel = 5'd3; iu_wdata = 32'h0000_1234;
    @(negedge clk);
    checks++; if (iu_gnt !== 1'b1) begin errors++; $display("FAIL rm_grant: got %b want 1", iu_gnt); end
    tick();  // N+1
    rst = 1'b1;
    idle();
    @(negedge clk);
    if (asr_wr !== 1'b0) wr_seen++;
    for (int c = 2; c <= 5; c++) begin
      tick();
      rst = 1'b0;
      @(negedge clk);
      if (asr_wr !== 1'b0) wr_seen++;
      if (c == 2) begin
        checks++;
        if (iu_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) begin
          errors++; $display("FAIL rm_rvalid: got iu=%b dbg=%b want 0 0", iu_rvalid, dbg_rvalid);
        end
      end
    end
    checks++;
    if (wr_seen !== 0) begin errors++; $display("FAIL rm_no_commit: got %0d write cycles want 0", wr_seen); end
  endtask

  initial begin
    test_reset();
    test_delayed_write();
    test_no_hazard();
    test_sel0();
    test_back_to_back();
`ifdef ASR_ARB_DEBUG_PORT_EN
    test_starvation();
    test_dbg_write();
`else
    test_macro_off();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
